// File: rtl/balance_wallet.sv
// balance_wallet: debounced top-up buttons plus a charge FSM over a saturating balance.
module balance_wallet #(
    parameter int BAL_W      = 12,
    parameter int MAX_BAL    = 999,
    parameter int SMALL_STEP = 1,
    parameter int BIG_STEP   = 10,
    parameter int DEB_CYC    = 1_000_000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_add1,
    input  logic             btn_add10,
    input  logic             chg_req,
    input  logic [BAL_W-1:0] chg_amt,
    output logic [BAL_W-1:0] bal,
    output logic             busy,
    output logic             chg_ack,
    output logic             chg_ok,
    output logic             sat
);
    typedef enum logic [1:0] {IDLE, CHECK, DEDUCT, FAIL} state_t;
    localparam int CW = $clog2(DEB_CYC + 1);

    state_t           state, state_n;
    logic [BAL_W-1:0] amt_q, amt_n, bal_n, credit;
    logic [BAL_W:0]   sum;
    logic [1:0]       raw, rise, pend, pend_n;
    logic             ack_n, ok_n, sat_n;

    assign raw = {btn_add10, btn_add1};

    genvar i;
    generate
        for (i = 0; i < 2; i++) begin : g_deb
            logic          s1, s2, deb;
            logic [CW-1:0] cnt;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    s1  <= 1'b0;
                    s2  <= 1'b0;
                    deb <= 1'b0;
                    cnt <= '0;
                end else begin
                    s1 <= raw[i];
                    s2 <= s1;
                    if (s2 == deb)
                        cnt <= '0;
                    else if (cnt == CW'(DEB_CYC - 1)) begin
                        cnt <= '0;
                        deb <= s2;
                    end else
                        cnt <= cnt + 1'b1;
                end
            end
            // the cycle in which the debounced level is about to go high
            assign rise[i] = !deb && s2 && (cnt == CW'(DEB_CYC - 1));
        end
    endgenerate

    assign credit = (pend[0] ? BAL_W'(SMALL_STEP) : '0) + (pend[1] ? BAL_W'(BIG_STEP) : '0);
    assign sum    = {1'b0, bal} + {1'b0, credit};
    assign busy   = (state != IDLE);

    always_comb begin
        state_n = state;
        bal_n   = bal;
        amt_n   = amt_q;
        ack_n   = 1'b0;
        ok_n    = chg_ok;
        sat_n   = 1'b0;
        pend_n  = pend | rise;
        case (state)
            IDLE: begin
                // pending flags are consumed here; an edge on a flag being consumed is lost
                pend_n  = rise & ~pend;
                sat_n   = sum > (BAL_W + 1)'(MAX_BAL);
                bal_n   = sat_n ? BAL_W'(MAX_BAL) : sum[BAL_W-1:0];
                amt_n   = chg_req ? chg_amt : amt_q;
                state_n = chg_req ? CHECK : IDLE;
            end
            CHECK: state_n = (amt_q <= bal) ? DEDUCT : FAIL;
            DEDUCT: begin
                bal_n   = bal - amt_q;
                ack_n   = 1'b1;
                ok_n    = 1'b1;
                state_n = IDLE;
            end
            default: begin
                ack_n   = 1'b1;
                ok_n    = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            bal     <= '0;
            amt_q   <= '0;
            pend    <= '0;
            chg_ack <= 1'b0;
            chg_ok  <= 1'b0;
            sat     <= 1'b0;
        end else begin
            state   <= state_n;
            bal     <= bal_n;
            amt_q   <= amt_n;
            pend    <= pend_n;
            chg_ack <= ack_n;
            chg_ok  <= ok_n;
            sat     <= sat_n;
        end
    end
endmodule

// File: tb/tb_balance_wallet.sv
// tb_balance_wallet: directed checks of debounced credits, charges, saturation and reset.
module tb_balance_wallet;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        btn_add1 = 1'b0;
    logic        btn_add10 = 1'b0;
    logic        chg_req = 1'b0;
    logic [11:0] chg_amt = '0;
    logic [11:0] bal;
    logic        busy, chg_ack, chg_ok, sat;
    int          passed = 0;
    int          total = 0;
    int          sat_cnt = 0;
    int          ack_cnt = 0;

    balance_wallet #(.DEB_CYC(4)) dut (
        .clk(clk), .rst(rst), .btn_add1(btn_add1), .btn_add10(btn_add10),
        .chg_req(chg_req), .chg_amt(chg_amt), .bal(bal), .busy(busy),
        .chg_ack(chg_ack), .chg_ok(chg_ok), .sat(sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // hold the chosen buttons 10 cycles, release, let the debouncer settle; counts sat pulses
    task automatic press(input logic b1, input logic b10);
        for (int c = 0; c < 22; c++) begin
            @(negedge clk);
            sat_cnt += int'(sat);
            btn_add1  = b1 && c < 10;
            btn_add10 = b10 && c < 10;
        end
    endtask

    task automatic charge(input string tag, input logic [11:0] amt, input logic poke,
                          input logic [11:0] pre, input logic ok, input logic [11:0] post);
        @(negedge clk);
        chg_req = 1'b1;
        chg_amt = amt;
        @(negedge clk);
        chk({tag, "_busy1"}, busy, 1);
        chk({tag, "_ack1"}, chg_ack, 0);
        chg_req = poke;
        chg_amt = '0;
        @(negedge clk);
        chk({tag, "_busy2"}, busy, 1);
        chk({tag, "_bal2"}, bal, pre);
        chg_req = 1'b0;
        @(negedge clk);
        chk({tag, "_ack"}, chg_ack, 1);
        chk({tag, "_ok"}, chg_ok, ok);
        chk({tag, "_bal"}, bal, post);
        chk({tag, "_idle"}, busy, 0);
        @(negedge clk);
        chk({tag, "_ackdrop"}, chg_ack, 0);
        chk({tag, "_okhold"}, chg_ok, ok);
        chk({tag, "_nobusy"}, busy, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_bal", bal, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ack", chg_ack, 0);
        chk("rst_ok", chg_ok, 0);
        chk("rst_sat", sat, 0);
        rst = 1'b1;

        press(1'b0, 1'b1);
        chk("add10_a", bal, 10);
        press(1'b0, 1'b1);
        chk("add10_b", bal, 20);
        press(1'b0, 1'b1);
        chk("add10_c", bal, 30);

        // bouncy hold: 2-cycle drops after the level has settled high
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            btn_add1 = !(c >= 8 && (c % 12 == 8 || c % 12 == 9));
        end
        @(negedge clk);
        btn_add1 = 1'b0;
        repeat (15) @(negedge clk);
        chk("bounce", bal, 31);

        charge("chg26", 12'd26, 1'b0, 12'd31, 1'b1, 12'd5);
        charge("chg6", 12'd6, 1'b1, 12'd5, 1'b0, 12'd5);

        sat_cnt = 0;
        for (int n = 0; n < 99; n++) press(1'b0, 1'b1);
        chk("fill_bal", bal, 995);
        chk("fill_nosat", sat_cnt, 0);
        press(1'b0, 1'b1);
        chk("clip_bal", bal, 999);
        chk("clip_sat", sat_cnt, 1);
        press(1'b1, 1'b0);
        chk("clip1_bal", bal, 999);
        chk("clip1_sat", sat_cnt, 2);

        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst2_bal", bal, 0);
        rst = 1'b1;
        sat_cnt = 0;
        press(1'b1, 1'b1);
        chk("both_bal", bal, 11);
        chk("both_nosat", sat_cnt, 0);
        charge("chgall", 12'd11, 1'b0, 12'd11, 1'b1, 12'd0);
        press(1'b1, 1'b0);
        chk("add1", bal, 1);

        @(negedge clk);
        chg_req = 1'b1;
        chg_amt = 12'd1;
        @(negedge clk);
        chk("mid_busy", busy, 1);
        chg_req = 1'b0;
        rst = 1'b0;
        #1;
        chk("mid_bal", bal, 0);
        chk("mid_idle", busy, 0);
        chk("mid_ack", chg_ack, 0);
        @(negedge clk);
        rst = 1'b1;
        ack_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            ack_cnt += int'(chg_ack);
        end
        chk("mid_noack", ack_cnt, 0);
        charge("chg0", 12'd0, 1'b0, 12'd0, 1'b1, 12'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
